// File: rtl/nominal_model_mc_pkg.sv
// Shared definitions for the multi-channel nominal plant model.
// Holds default fixed-point parameters, the controller and phase state
// types, and a helper that sizes the channel counter.
package nominal_model_mc_pkg;

  localparam int unsigned NMM_NCH_DEF       = 4;
  localparam int unsigned NMM_W_DEF         = 32;
  localparam int unsigned NMM_FRAC_DEF      = 10;
  localparam int unsigned NMM_TS_DEF        = 163;
  localparam int unsigned NMM_TS_FRAC_DEF   = 22;
  localparam int          NMM_GAIN_DEF      = 512;
  localparam int unsigned NMM_GAIN_FRAC_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } nmm_state_t;

  // One multiply per phase: acceleration, velocity update, position update.
  typedef enum logic [1:0] {
    PH_ACC = 2'd0,
    PH_VEL = 2'd1,
    PH_POS = 2'd2
  } nmm_phase_t;

  function automatic int unsigned nmm_ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nominal_model_mc_if.sv
// Frame handshake and data bus of the nominal plant model.
//   in_valid/in_ready : input frame handshake (master -> slave)
//   clear             : request to zero integrator state
//   u_t               : NCH control inputs, channel k at [k*W +: W]
//   model_u/model_udot: nominal position / velocity per channel
//   out_valid         : one-cycle pulse when all channels are updated
interface nominal_model_mc_if
  import nominal_model_mc_pkg::*;
#(
  parameter int unsigned NCH = NMM_NCH_DEF,
  parameter int unsigned W   = NMM_W_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic             clear;
  logic [NCH*W-1:0] u_t;
  logic [NCH*W-1:0] model_u;
  logic [NCH*W-1:0] model_udot;
  logic             out_valid;

  modport master (
    output in_valid, clear, u_t,
    input  in_ready, model_u, model_udot, out_valid
  );

  modport slave (
    input  in_valid, clear, u_t,
    output in_ready, model_u, model_udot, out_valid
  );

endinterface

// File: rtl/nmm_mul_sat.sv
// Shared arithmetic unit: signed WxW multiply, arithmetic right shift
// (floor toward -inf), saturation to W bits, then an optional saturating
// add of an accumulator input.
//   i_a, i_b     : signed multiplicands
//   i_shift_alt  : 0 -> shift by SHIFT, 1 -> shift by SHIFT_ALT
//   i_acc        : accumulator operand, added when i_acc_en=1
//   o_y          : saturated W-bit result
module nmm_mul_sat
  import nominal_model_mc_pkg::*;
#(
  parameter int unsigned W         = NMM_W_DEF,
  parameter int unsigned SHIFT     = NMM_TS_FRAC_DEF,
  parameter int unsigned SHIFT_ALT = NMM_GAIN_FRAC_DEF
)(
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  input  logic                i_shift_alt,
  input  logic signed [W-1:0] i_acc,
  input  logic                i_acc_en,
  output logic signed [W-1:0] o_y
);

  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  logic signed [2*W-1:0] w_prod;
  logic signed [2*W-1:0] w_shr;
  logic signed [W-1:0]   w_psat;
  logic        [W:0]     w_sum;

  assign w_prod = i_a * i_b;
  assign w_shr  = w_prod >>> (i_shift_alt ? SHIFT_ALT : SHIFT);

  // The shifted product fits in W bits only if its top W+1 bits agree.
  always_comb begin
    w_psat = w_shr[W-1:0];
    if ((w_shr[2*W-1:W-1] != '0) && (w_shr[2*W-1:W-1] != '1)) begin
      w_psat = w_shr[2*W-1] ? SAT_MIN : SAT_MAX;
    end
  end

  always_comb begin
    w_sum = {i_acc[W-1], i_acc} + {w_psat[W-1], w_psat};
    o_y   = w_psat;
    if (i_acc_en) begin
      o_y = w_sum[W-1:0];
      if (w_sum[W] != w_sum[W-1]) begin
        o_y = w_sum[W] ? SAT_MIN : SAT_MAX;
      end
    end
  end

endmodule

// File: rtl/nominal_model_mc.sv
// Multi-channel nominal double-integrator plant model
//   theta_dd = GAIN*u; theta_d += Ts*theta_dd; theta += Ts*theta_d
// for NCH axes, time-multiplexed through one multiplier (3 cycles/channel).
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of nominal_model_mc_if (handshake, u_t, clear,
//          model_u/model_udot outputs, out_valid pulse)
module nominal_model_mc
  import nominal_model_mc_pkg::*;
#(
  parameter int unsigned NCH       = NMM_NCH_DEF,
  parameter int unsigned W         = NMM_W_DEF,
  parameter int unsigned FRAC      = NMM_FRAC_DEF,
  parameter int unsigned TS        = NMM_TS_DEF,
  parameter int unsigned TS_FRAC   = NMM_TS_FRAC_DEF,
  parameter int          GAIN      = NMM_GAIN_DEF,
  parameter int unsigned GAIN_FRAC = NMM_GAIN_FRAC_DEF
)(
  input  logic               clk,
  input  logic               rst,
  nominal_model_mc_if.slave  bus
);

  localparam int unsigned         CW      = nmm_ch_width(NCH);
  localparam logic [CW-1:0]       CH_LAST = CW'(NCH - 1);
  localparam logic signed [W-1:0] TS_W    = W'(TS);
  localparam logic signed [W-1:0] GAIN_W  = W'(GAIN);

  nmm_state_t          r_state;
  nmm_phase_t          r_ph;
  logic [CW-1:0]       r_ch;
  logic signed [W-1:0] r_u [NCH];
  logic signed [W-1:0] r_v [NCH];
  logic signed [W-1:0] r_p [NCH];
  logic signed [W-1:0] r_a;
  logic signed [W-1:0] r_vn;
  logic                r_clr_pend;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [NCH*W-1:0]    r_model_u;
  logic [NCH*W-1:0]    r_model_udot;

  logic signed [W-1:0] w_mul_a;
  logic signed [W-1:0] w_mul_b;
  logic signed [W-1:0] w_mul_acc;
  logic signed [W-1:0] w_mul_y;
  logic                w_acc_en;
  logic                w_shift_alt;
  logic                w_accept;
  logic                w_clr_now;

  assign w_accept  = bus.in_valid & r_in_ready;
  // A clear requested during a frame is applied on the first IDLE cycle.
  assign w_clr_now = bus.clear | r_clr_pend;

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.model_u    = r_model_u;
  assign bus.model_udot = r_model_udot;

  // Operand steering for the shared multiplier.
  always_comb begin
    w_mul_a     = r_u[r_ch];
    w_mul_b     = GAIN_W;
    w_mul_acc   = '0;
    w_acc_en    = 1'b0;
    w_shift_alt = 1'b1;
    case (r_ph)
      PH_VEL: begin
        w_mul_a     = r_a;
        w_mul_b     = TS_W;
        w_mul_acc   = r_v[r_ch];
        w_acc_en    = 1'b1;
        w_shift_alt = 1'b0;
      end
      PH_POS: begin
        // The freshly computed velocity drives the position update.
        w_mul_a     = r_vn;
        w_mul_b     = TS_W;
        w_mul_acc   = r_p[r_ch];
        w_acc_en    = 1'b1;
        w_shift_alt = 1'b0;
      end
      default: ;
    endcase
  end

  nmm_mul_sat #(
    .W         (W),
    .SHIFT     (TS_FRAC),
    .SHIFT_ALT (GAIN_FRAC)
  ) u_mul (
    .i_a         (w_mul_a),
    .i_b         (w_mul_b),
    .i_shift_alt (w_shift_alt),
    .i_acc       (w_mul_acc),
    .i_acc_en    (w_acc_en),
    .o_y         (w_mul_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ph         <= PH_ACC;
      r_ch         <= '0;
      r_a          <= '0;
      r_vn         <= '0;
      r_clr_pend   <= 1'b0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_model_u    <= '0;
      r_model_udot <= '0;
      for (int unsigned k = 0; k < NCH; k++) begin
        r_u[k] <= '0;
        r_v[k] <= '0;
        r_p[k] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_clr_now) begin
            r_clr_pend   <= 1'b0;
            r_model_u    <= '0;
            r_model_udot <= '0;
            for (int unsigned k = 0; k < NCH; k++) begin
              r_v[k] <= '0;
              r_p[k] <= '0;
            end
          end
          if (w_accept) begin
            for (int unsigned k = 0; k < NCH; k++) begin
              r_u[k] <= bus.u_t[k*W +: W];
            end
            r_ch       <= '0;
            r_ph       <= PH_ACC;
            r_in_ready <= 1'b0;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus.clear) r_clr_pend <= 1'b1;
          case (r_ph)
            PH_ACC: begin
              r_a  <= w_mul_y;
              r_ph <= PH_VEL;
            end
            PH_VEL: begin
              r_vn <= w_mul_y;
              r_ph <= PH_POS;
            end
            default: begin
              r_v[r_ch] <= r_vn;
              r_p[r_ch] <= w_mul_y;
              r_ph      <= PH_ACC;
              if (r_ch == CH_LAST) r_state <= ST_DONE;
              else                 r_ch    <= r_ch + 1'b1;
            end
          endcase
        end
        default: begin
          if (bus.clear) r_clr_pend <= 1'b1;
          for (int unsigned k = 0; k < NCH; k++) begin
            r_model_u[k*W +: W]    <= r_p[k];
            r_model_udot[k*W +: W] <= r_v[k];
          end
          r_out_valid <= 1'b1;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nominal_model_mc.sv
module tb_nominal_model_mc;

  localparam int NCH     = 4;
  localparam int W       = 32;
  localparam int TS_HALF = 2097152;
  localparam int LAT     = 3*NCH + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid [3];
  logic             clear    [3];
  logic [NCH*W-1:0] u_t      [3];

  int checks = 0;
  int errors = 0;

  nominal_model_mc_if #(.NCH(NCH), .W(W)) if0 (), if1 (), if2 ();

  assign if0.in_valid = in_valid[0];
  assign if0.clear    = clear[0];
  assign if0.u_t      = u_t[0];
  assign if1.in_valid = in_valid[1];
  assign if1.clear    = clear[1];
  assign if1.u_t      = u_t[1];
  assign if2.in_valid = in_valid[2];
  assign if2.clear    = clear[2];
  assign if2.u_t      = u_t[2];

  nominal_model_mc #(.NCH(NCH), .W(W), .FRAC(10), .TS(TS_HALF), .TS_FRAC(22),
                     .GAIN(512), .GAIN_FRAC(10))
    dut_main (.clk(clk), .rst(rst), .bus(if0));
  nominal_model_mc #(.NCH(NCH), .W(W), .FRAC(10), .TS(TS_HALF), .TS_FRAC(22),
                     .GAIN(1048576), .GAIN_FRAC(10))
    dut_sat (.clk(clk), .rst(rst), .bus(if1));
  nominal_model_mc #(.NCH(NCH), .W(W))
    dut_def (.clk(clk), .rst(rst), .bus(if2));

  // ---------------- reference model (real-number rules, 64-bit) ----------
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  longint gain_m [3] = '{512, 1048576, 512};
  longint ts_m   [3] = '{2097152, 2097152, 163};
  longint mv [3][NCH];
  longint mp [3][NCH];

  function automatic longint sat(input longint x);
    if (x > SMAX) return SMAX;
    if (x < SMIN) return SMIN;
    return x;
  endfunction

  // floor(x / 2^sh), rounding toward minus infinity
  function automatic longint floor_scaled(input longint x, input int sh);
    longint d = longint'(1) << sh;
    longint m = x % d;
    if (m < 0) m += d;
    return (x - m) / d;
  endfunction

  function automatic void model_clear(input int d);
    for (int k = 0; k < NCH; k++) begin
      mv[d][k] = 0;
      mp[d][k] = 0;
    end
  endfunction

  function automatic void model_frame(input int d, input logic [NCH*W-1:0] u);
    for (int k = 0; k < NCH; k++) begin
      longint uk = longint'($signed(u[k*W +: W]));
      longint a  = sat(floor_scaled(uk * gain_m[d], 10));
      mv[d][k] = sat(mv[d][k] + sat(floor_scaled(a * ts_m[d], 22)));
      mp[d][k] = sat(mp[d][k] + sat(floor_scaled(mv[d][k] * ts_m[d], 22)));
    end
  endfunction

  function automatic logic [NCH*W-1:0] exp_vec(input int d, input bit pos);
    logic [NCH*W-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*W +: W] = W'(pos ? mp[d][k] : mv[d][k]);
    return r;
  endfunction

  function automatic logic [NCH*W-1:0] splat(input logic [W-1:0] x);
    logic [NCH*W-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*W +: W] = x;
    return r;
  endfunction

  // ---------------- DUT accessors ----------------------------------------
  function automatic logic get_ov(input int d);
    case (d)
      0: return if0.out_valid;
      1: return if1.out_valid;
      default: return if2.out_valid;
    endcase
  endfunction

  function automatic logic get_rdy(input int d);
    case (d)
      0: return if0.in_ready;
      1: return if1.in_ready;
      default: return if2.in_ready;
    endcase
  endfunction

  function automatic logic [NCH*W-1:0] get_mu(input int d);
    case (d)
      0: return if0.model_u;
      1: return if1.model_u;
      default: return if2.model_u;
    endcase
  endfunction

  function automatic logic [NCH*W-1:0] get_mud(input int d);
    case (d)
      0: return if0.model_udot;
      1: return if1.model_udot;
      default: return if2.model_udot;
    endcase
  endfunction

  // Drive one frame; clr_cyc=0 asserts clear with the accept, n>0 pulses it
  // n cycles later; in_valid stays high for hold_cyc cycles after accept.
  // Returns cycles from accept edge to out_valid (60 on timeout).
  task automatic send(input int d, input logic [NCH*W-1:0] u, input int clr_cyc,
                      input int hold_cyc, output int lat);
    @(negedge clk);
    u_t[d]      = u;
    in_valid[d] = 1'b1;
    clear[d]    = (clr_cyc == 0);
    @(posedge clk);
    #1;
    clear[d] = 1'b0;
    if (hold_cyc == 0) in_valid[d] = 1'b0;
    else               u_t[d] = ~u;
    lat = 0;
    while (lat < 60) begin
      @(posedge clk);
      lat++;
      #1;
      clear[d] = (lat == clr_cyc);
      if (lat >= hold_cyc) in_valid[d] = 1'b0;
      if (get_ov(d)) break;
    end
    clear[d]    = 1'b0;
    in_valid[d] = 1'b0;
  endtask

  task automatic idle_clear(input int d);
    @(negedge clk);
    clear[d] = 1'b1;
    @(negedge clk);
    clear[d] = 1'b0;
    model_clear(d);
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      model_clear(d);
      checks++; if (get_rdy(d) !== 1'b1) begin errors++; $display("FAIL reset_in_ready dut%0d got=%b exp=1", d, get_rdy(d)); end
      checks++; if (get_ov(d) !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut%0d got=%b exp=0", d, get_ov(d)); end
      checks++; if (get_mu(d) !== '0) begin errors++; $display("FAIL reset_model_u dut%0d got=%h exp=0", d, get_mu(d)); end
      checks++; if (get_mud(d) !== '0) begin errors++; $display("FAIL reset_model_udot dut%0d got=%h exp=0", d, get_mud(d)); end
    end
  endtask

  task automatic test_basic();
    int lat;
    logic [NCH*W-1:0] u = splat(32'd1024);
    for (int f = 0; f < 2; f++) begin
      send(0, u, -1, 0, lat);
      model_frame(0, u);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL basic_latency f%0d got=%0d exp=%0d", f, lat, LAT); end
      checks++; if (get_mud(0) !== exp_vec(0, 0)) begin errors++; $display("FAIL basic_udot f%0d got=%h exp=%h", f, get_mud(0), exp_vec(0, 0)); end
      checks++; if (get_mu(0) !== exp_vec(0, 1)) begin errors++; $display("FAIL basic_u f%0d got=%h exp=%h", f, get_mu(0), exp_vec(0, 1)); end
    end
    checks++; if (get_mu(0) !== splat(32'd384)) begin errors++; $display("FAIL basic_u_abs got=%h exp=%h", get_mu(0), splat(32'd384)); end
    @(posedge clk); #1;
    checks++; if (get_ov(0) !== 1'b0) begin errors++; $display("FAIL out_valid_pulse got=%b exp=0", get_ov(0)); end
  endtask

  task automatic test_clear_idle();
    idle_clear(0);
    checks++; if (get_mu(0) !== '0 || get_mud(0) !== '0) begin errors++; $display("FAIL clear_idle got=%h/%h exp=0", get_mu(0), get_mud(0)); end
    checks++; if (get_ov(0) !== 1'b0) begin errors++; $display("FAIL clear_idle_ov got=%b exp=0", get_ov(0)); end
  endtask

  task automatic test_lanes();
    int lat;
    logic [NCH*W-1:0] u = {32'd2048, 32'd0, 32'hFFFFFC00, 32'd1024};
    logic [NCH*W-1:0] e = {32'd512, 32'd0, 32'hFFFFFF00, 32'd256};
    send(0, u, -1, 0, lat);
    model_frame(0, u);
    checks++; if (get_mud(0) !== exp_vec(0, 0) || get_mud(0) !== e) begin errors++; $display("FAIL lanes_udot got=%h exp=%h", get_mud(0), e); end
    checks++; if (get_mu(0) !== exp_vec(0, 1)) begin errors++; $display("FAIL lanes_u got=%h exp=%h", get_mu(0), exp_vec(0, 1)); end
  endtask

  task automatic test_truncation();
    int lat;
    idle_clear(0);
    send(0, splat(32'd1), -1, 0, lat);
    model_frame(0, splat(32'd1));
    checks++; if (get_mu(0) !== '0 || get_mud(0) !== '0) begin errors++; $display("FAIL trunc_pos got=%h/%h exp=0", get_mu(0), get_mud(0)); end
    send(0, splat(32'hFFFFFFFF), -1, 0, lat);
    model_frame(0, splat(32'hFFFFFFFF));
    checks++; if (get_mud(0) !== exp_vec(0, 0) || get_mud(0) !== '1) begin errors++; $display("FAIL trunc_neg_udot got=%h exp=%h", get_mud(0), exp_vec(0, 0)); end
    checks++; if (get_mu(0) !== exp_vec(0, 1) || get_mu(0) !== '1) begin errors++; $display("FAIL trunc_neg_u got=%h exp=%h", get_mu(0), exp_vec(0, 1)); end
  endtask

  task automatic test_saturation();
    int lat;
    for (int f = 0; f < 18; f++) begin
      logic [NCH*W-1:0] u = splat(f < 6 ? 32'h7FFFFFFF : 32'h80000000);
      send(1, u, -1, 0, lat);
      model_frame(1, u);
      checks++; if (get_mud(1) !== exp_vec(1, 0) || get_mu(1) !== exp_vec(1, 1)) begin
        errors++; $display("FAIL sat_frame f%0d got=%h/%h exp=%h/%h", f, get_mud(1), get_mu(1), exp_vec(1, 0), exp_vec(1, 1));
      end
      if (f == 5) begin
        checks++; if (get_mu(1) !== splat(32'h7FFFFFFF) || get_mud(1) !== splat(32'h7FFFFFFF)) begin errors++; $display("FAIL sat_max got=%h/%h exp=7fffffff", get_mu(1), get_mud(1)); end
      end
    end
    checks++; if (get_mu(1) !== splat(32'h80000000) || get_mud(1) !== splat(32'h80000000)) begin errors++; $display("FAIL sat_min got=%h/%h exp=80000000", get_mu(1), get_mud(1)); end
  endtask

  task automatic test_pending_clear();
    int lat;
    logic [NCH*W-1:0] u = splat(32'd1024);
    idle_clear(0);
    send(0, u, -1, 0, lat);
    model_frame(0, u);
    send(0, u, 5, 0, lat);
    model_frame(0, u);
    checks++; if (lat !== LAT || get_mud(0) !== splat(32'd512) || get_mu(0) !== exp_vec(0, 1)) begin
      errors++; $display("FAIL pend_frame lat=%0d got=%h/%h exp=%h/%h", lat, get_mud(0), get_mu(0), exp_vec(0, 0), exp_vec(0, 1));
    end
    model_clear(0);
    @(posedge clk); #1;
    checks++; if (get_mu(0) !== '0 || get_mud(0) !== '0 || get_ov(0) !== 1'b0) begin errors++; $display("FAIL pend_zero got=%h/%h ov=%b exp=0", get_mu(0), get_mud(0), get_ov(0)); end
    send(0, u, -1, 0, lat);
    model_frame(0, u);
    checks++; if (get_mud(0) !== exp_vec(0, 0) || get_mu(0) !== splat(32'd128)) begin errors++; $display("FAIL pend_next got=%h/%h exp=%h/%h", get_mud(0), get_mu(0), exp_vec(0, 0), exp_vec(0, 1)); end
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int f = 0; f < 10; f++) begin
      logic [NCH*W-1:0] u;
      int csel = $urandom_range(0, 3);
      for (int k = 0; k < NCH; k++) begin
        case ($urandom_range(0, 2))
          0:       u[k*W +: W] = $urandom;
          1:       u[k*W +: W] = W'($urandom_range(0, 8192)) - 32'd4096;
          default: u[k*W +: W] = W'($urandom_range(0, 33554432)) - 32'd16777216;
        endcase
      end
      if (csel == 0) model_clear(0);
      send(0, u, (csel == 0) ? 0 : (csel == 1) ? 4 : -1, 0, lat);
      model_frame(0, u);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL b2b_latency f%0d got=%0d exp=%0d", f, lat, LAT); end
      checks++; if (get_mud(0) !== exp_vec(0, 0) || get_mu(0) !== exp_vec(0, 1)) begin
        errors++; $display("FAIL b2b_data f%0d got=%h/%h exp=%h/%h", f, get_mud(0), get_mu(0), exp_vec(0, 0), exp_vec(0, 1));
      end
      if (csel == 1) model_clear(0);
    end
  endtask

  task automatic test_no_queue();
    int lat;
    int seen = 0;
    logic [NCH*W-1:0] u = splat(32'd2048);
    send(0, u, -1, 5, lat);
    model_frame(0, u);
    checks++; if (get_mud(0) !== exp_vec(0, 0) || get_mu(0) !== exp_vec(0, 1)) begin errors++; $display("FAIL noq_data got=%h/%h exp=%h/%h", get_mud(0), get_mu(0), exp_vec(0, 0), exp_vec(0, 1)); end
    repeat (20) begin
      @(posedge clk); #1;
      if (get_ov(0)) seen++;
    end
    checks++; if (seen !== 0 || get_rdy(0) !== 1'b1) begin errors++; $display("FAIL noq_extra_frame got=%0d rdy=%b exp=0 rdy=1", seen, get_rdy(0)); end
  endtask

  task automatic test_default_ts();
    int lat;
    send(2, splat(32'd1024), -1, 0, lat);
    model_frame(2, splat(32'd1024));
    checks++; if (get_mud(2) !== '0 || get_mu(2) !== '0 || lat !== LAT) begin errors++; $display("FAIL def_ts_sublsb got=%h/%h lat=%0d exp=0", get_mud(2), get_mu(2), lat); end
    send(2, splat(32'h00100000), -1, 0, lat);
    model_frame(2, splat(32'h00100000));
    checks++; if (get_mud(2) !== exp_vec(2, 0) || get_mu(2) !== exp_vec(2, 1)) begin errors++; $display("FAIL def_ts_big got=%h/%h exp=%h/%h", get_mud(2), get_mu(2), exp_vec(2, 0), exp_vec(2, 1)); end
  endtask

  task automatic test_reset_midframe();
    int seen = 0;
    checks++; if (get_mu(0) === '0) begin errors++; $display("FAIL rst_pre_state got=%h exp=nonzero", get_mu(0)); end
    @(negedge clk);
    u_t[0]      = splat(32'd1024);
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    checks++; if (get_rdy(0) !== 1'b0) begin errors++; $display("FAIL busy_in_ready got=%b exp=0", get_rdy(0)); end
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int d = 0; d < 3; d++) model_clear(d);
    repeat (20) begin
      @(posedge clk); #1;
      if (get_ov(0)) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_abort_ov got=%0d exp=0", seen); end
    checks++; if (get_mu(0) !== '0 || get_mud(0) !== '0 || get_rdy(0) !== 1'b1) begin errors++; $display("FAIL rst_abort_state got=%h/%h rdy=%b exp=0/0 rdy=1", get_mu(0), get_mud(0), get_rdy(0)); end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0;
      clear[d]    = 1'b0;
      u_t[d]      = '0;
    end
    test_reset();
    test_basic();
    test_clear_idle();
    test_lanes();
    test_truncation();
    test_saturation();
    test_pending_clear();
    test_back_to_back();
    test_no_queue();
    test_default_ts();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
